lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store initiator between the execute/memory pipeline stage and data memory (big-endian, byte-addressed).
//  Accepts one request at a time over a valid/ready handshake and maps RISC-V funct3 to the memory access-mode code.
//  Drives the memory's rd_en/wr_en/addr/mem_acc_mode/wdata for MEM_LAT cycles, then samples load data.
//  Returns one response per request over a valid/ready handshake. Checks bounds and illegal encodings before any access.
// PARAMETERS
//  MEM_BYTES  100  size of data memory in bytes; accesses with addr+size > MEM_BYTES are rejected
//  MEM_LAT    1    cycles the access is held on the memory port (>=1); load data sampled on the last one
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst           in   1   synchronous reset, active-high
//  req_valid     in   1   pipeline request present
//  req_ready     out  1   1 in IDLE and rst=0; request accepted when req_valid&&req_ready
//  req_is_store  in   1   1=store, 0=load
//  req_funct3    in   3   RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned
//  resp_valid    out  1   response present; held until resp_ready
//  resp_ready    in   1   pipeline consumes response
//  resp_rdata    out  32  load result, extended per funct3; 0 for stores and errors
//  resp_err      out  1   request rejected, no memory access performed
//  mem_rd_en     out  1   memory read enable
//  mem_wr_en     out  1   memory write enable
//  mem_addr      out  32  memory byte address
//  mem_acc_mode  out  3   000 B, 001 H, 010 W, 011 BU, 100 HU
//  mem_wdata     out  32  memory write data
//  mem_rdata     in   32  memory async read data; valid only while mem_rd_en=1
// BEHAVIOUR
//  States IDLE -> ACCESS -> RESP -> IDLE; rejected requests go IDLE -> RESP directly.
//  Reset: state=IDLE, cnt=0, resp_valid=0, resp_err=0, resp_rdata=0, all mem_* outputs 0, req_ready=0 while rst=1.
//  IDLE: on accept, register is_store, mode, addr, wdata.
//   - funct3 map: 000->000, 001->001, 010->010, 100->011, 101->100.
//   - Loads with 011/110/111, stores with funct3>=011, or addr+size>MEM_BYTES (size 1/2/4; compute in 33 bits) -> resp_err=1 -> RESP.
//  ACCESS: mem_addr/mem_acc_mode/mem_wdata driven from the registered request.
//   - cnt counts 0..MEM_LAT-1.
//   - Load: mem_rd_en=1 every ACCESS cycle. On the edge ending cnt==MEM_LAT-1, resp_rdata<=mem_rdata.
//   - Store: mem_wr_en=1 only when cnt==MEM_LAT-1, giving exactly one write edge.
//   - ACCESS -> RESP after cnt==MEM_LAT-1.
//  RESP: resp_valid=1, outputs stable until resp_ready=1, then -> IDLE.
//   - req_ready=0 in RESP, so no back-to-back accept; peak throughput is 1 per MEM_LAT+2 cycles.
//  mem_* outputs are 0 outside ACCESS. mem_rd_en and mem_wr_en are gated with !rst.
//   - Reset asserted on an ACCESS write cycle suppresses that write. Reset mid-ACCESS discards the request; no response.
//  req_* inputs are ignored outside IDLE. Changes after acceptance have no effect.
//  resp_rdata is 0 for store responses. resp_err is cleared on the next accept.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - H/HU with addr[0]!=0 or W with addr[1:0]!=0 -> resp_err=1, no mem_* activity, IDLE -> RESP.
//  Not defined:
//   - Unaligned addresses pass through unchanged; memory handles them byte-wise. Only the bounds/funct3 checks apply.
// TESTING
//  SW 0xDEADBEEF @8, then LW @8 -> resp_rdata=0xDEADBEEF, resp_err=0. Write issued on exactly 1 edge; resp_valid 2 cycles after accept (MEM_LAT=1).
//  After above: LB @8 -> 0xFFFFFFDE; LBU @9 -> 0x000000AD; LH @10 -> 0xFFFFBEEF; LHU @10 -> 0x0000BEEF.
//  LW @98 -> resp_err=1, mem_rd_en never high. SW @96 -> ok. Load funct3=110 -> resp_err=1.
//  MEM_LAT=3, LW with resp_ready=0 for 4 cycles -> mem_rd_en high 3 cycles; resp_valid/rdata held stable; req_ready=0 until consumed.
//  rst=1 on the ACCESS cycle of SW 0x11223344 @0 -> mem_wr_en=0. LW @0 after reset returns prior contents. Outputs at reset values.
//  MISALIGN_TRAP_EN: LH @5 -> resp_err=1, no access. Without it: SH 0xABCD @5, then LHU @5 -> 0x0000ABCD.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute/memory stage and big-endian byte-addressed data memory.
// Optional build macro MISALIGN_TRAP_EN rejects misaligned halfword/word accesses instead of passing them through.
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 100,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_acc_mode,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_store_q;
    logic [2:0]    mode_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;

    logic [2:0]    mode_c;
    logic          f3_ok_c;
    logic [32:0]   size_c;
    logic          out_of_range_c;
    logic          misalign_c;
    logic          reject_c;
    logic [31:0]   load_ext_c;

    // Request decode: funct3 -> access mode, legality, bounds and alignment
    always_comb begin
        mode_c  = 3'b000;
        f3_ok_c = 1'b0;
        case (req_funct3)
            3'b000: begin mode_c = 3'b000; f3_ok_c = 1'b1;          end
            3'b001: begin mode_c = 3'b001; f3_ok_c = 1'b1;          end
            3'b010: begin mode_c = 3'b010; f3_ok_c = 1'b1;          end
            3'b100: begin mode_c = 3'b011; f3_ok_c = !req_is_store; end
            3'b101: begin mode_c = 3'b100; f3_ok_c = !req_is_store; end
            default: begin mode_c = 3'b000; f3_ok_c = 1'b0;         end
        endcase

        case (req_funct3[1:0])
            2'b00:   size_c = 33'd1;
            2'b01:   size_c = 33'd2;
            default: size_c = 33'd4;
        endcase

        // 33-bit sum so addresses near 2^32 cannot wrap back into range
        out_of_range_c = ({1'b0, req_addr} + size_c) > 33'(MEM_BYTES);

`ifdef MISALIGN_TRAP_EN
        misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
`endif

        reject_c = !f3_ok_c || out_of_range_c || misalign_c;
    end

    // Load result extension from the right-aligned memory data
    always_comb begin
        case (mode_q)
            3'b000:  load_ext_c = {{24{mem_rdata[7]}},  mem_rdata[7:0]};
            3'b001:  load_ext_c = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b011:  load_ext_c = {24'h000000, mem_rdata[7:0]};
            3'b100:  load_ext_c = {16'h0000, mem_rdata[15:0]};
            default: load_ext_c = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_store_q <= 1'b0;
            mode_q     <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        mode_q     <= mode_c;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        cnt        <= '0;
                        resp_rdata <= 32'h0;
                        if (reject_c) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            resp_err <= 1'b0;
                            state    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                        if (!is_store_q) begin
                            resp_rdata <= load_ext_c;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Enables gated by rst so a reset landing on the write cycle suppresses the write
    assign req_ready    = (state == IDLE) && !rst;
    assign mem_rd_en    = (state == ACCESS) && !is_store_q && !rst;
    assign mem_wr_en    = (state == ACCESS) && is_store_q && (cnt == CNT_LAST) && !rst;
    assign mem_addr     = (state == ACCESS) ? addr_q  : 32'h0;
    assign mem_acc_mode = (state == ACCESS) ? mode_q  : 3'b000;
    assign mem_wdata    = (state == ACCESS) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3,
// each backed by its own 100-byte big-endian memory model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        resp_valid   [2];
    logic        resp_ready   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];
    logic        mem_rd_en    [2];
    logic        mem_wr_en    [2];
    logic [31:0] mem_addr     [2];
    logic [2:0]  mem_acc_mode [2];
    logic [31:0] mem_wdata    [2];
    logic [31:0] mem_rdata    [2];
    int unsigned rd_cnt       [2];
    int unsigned wr_cnt       [2];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    function automatic int bytes_of(input logic [2:0] mode);
        case (mode)
            3'b000, 3'b011: return 1;
            3'b001, 3'b100: return 2;
            default:        return 4;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0]  mem [100];
        int unsigned rd_n = 0;
        int unsigned wr_n = 0;

        lsu_ctrl #(
            .MEM_BYTES(100),
            .MEM_LAT  ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_is_store(req_is_store),
            .req_funct3  (req_funct3),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .resp_valid  (resp_valid[g]),
            .resp_ready  (resp_ready[g]),
            .resp_rdata  (resp_rdata[g]),
            .resp_err    (resp_err[g]),
            .mem_rd_en   (mem_rd_en[g]),
            .mem_wr_en   (mem_wr_en[g]),
            .mem_addr    (mem_addr[g]),
            .mem_acc_mode(mem_acc_mode[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_rdata   (mem_rdata[g])
        );

        always @(posedge clk) begin
            if (mem_wr_en[g]) begin
                for (int k = 0; k < 4; k++) begin
                    if (k < bytes_of(mem_acc_mode[g]) && (int'(mem_addr[g]) + k) < 100)
                        mem[int'(mem_addr[g]) + k] <= mem_wdata[g][8*(bytes_of(mem_acc_mode[g])-1-k) +: 8];
                end
                wr_n <= wr_n + 1;
            end
            if (mem_rd_en[g]) rd_n <= rd_n + 1;
        end

        // Right-aligned, zero-extended read data; garbage when not enabled
        always_comb begin
            mem_rdata[g] = 32'hA5A5_A5A5;
            if (mem_rd_en[g] && (int'(mem_addr[g]) + bytes_of(mem_acc_mode[g])) <= 100) begin
                mem_rdata[g] = 32'h0;
                for (int k = 0; k < 4; k++) begin
                    if (k < bytes_of(mem_acc_mode[g]))
                        mem_rdata[g] = {mem_rdata[g][23:0], mem[int'(mem_addr[g]) + k]};
                end
            end
        end

        assign rd_cnt[g] = rd_n;
        assign wr_cnt[g] = wr_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One request/response transaction; hold = cycles resp_ready stays low once resp_valid rises
    task automatic run_req(input string tag, input int g, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat,
                           input int exp_rds, input int exp_wrs);
        int unsigned rd0, wr0;
        int lat;
        logic [31:0] rdata;
        logic err;
        @(negedge clk);
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        req_valid[g] = 1'b1;
        rd0 = rd_cnt[g];
        wr0 = wr_cnt[g];
        check({tag, ".ready"}, 32'(req_ready[g]), 32'd1);
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        req_addr     = 32'hFFFF_FFF0;
        req_wdata    = ~wd;
        req_funct3   = 3'b111;
        lat = 1;
        while (!resp_valid[g] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid[g]) check({tag, ".timeout"}, 32'(resp_valid[g]), 32'd1);
        rdata = resp_rdata[g];
        err   = resp_err[g];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(resp_valid[g]), 32'd1);
            check({tag, ".hold_rdata"}, resp_rdata[g], rdata);
            check({tag, ".hold_ready"}, 32'(req_ready[g]), 32'd0);
        end
        resp_ready[g] = 1'b1;
        @(posedge clk); #1;
        resp_ready[g] = 1'b0;
        check({tag, ".rdata"},   rdata, exp_rdata);
        check({tag, ".err"},     32'(err), 32'(exp_err));
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rd_edges"}, 32'(rd_cnt[g] - rd0), 32'(exp_rds));
        check({tag, ".wr_edges"}, 32'(wr_cnt[g] - wr0), 32'(exp_wrs));
        check({tag, ".drop"},    32'(resp_valid[g]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_is_store = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            resp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst.req_ready",  32'(req_ready[0]), 32'd0);
        check("rst.resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst.resp_err",   32'(resp_err[0]), 32'd0);
        check("rst.resp_rdata", resp_rdata[0], 32'h0);
        check("rst.mem_en",     {30'h0, mem_rd_en[0], mem_wr_en[0]}, 32'h0);
        check("rst.mem_addr",   mem_addr[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // tag, inst, store, funct3, addr, wdata, hold, rdata, err, latency, rd edges, wr edges
        run_req("sw8",   0, 1, 3'b010, 32'd8,  32'hDEAD_BEEF, 0, 32'h0,         0, 2, 0, 1);
        run_req("lw8",   0, 0, 3'b010, 32'd8,  32'h0,         0, 32'hDEAD_BEEF, 0, 2, 1, 0);
        run_req("lb8",   0, 0, 3'b000, 32'd8,  32'h0,         0, 32'hFFFF_FFDE, 0, 2, 1, 0);
        run_req("lbu9",  0, 0, 3'b100, 32'd9,  32'h0,         0, 32'h0000_00AD, 0, 2, 1, 0);
        run_req("lh10",  0, 0, 3'b001, 32'd10, 32'h0,         0, 32'hFFFF_BEEF, 0, 2, 1, 0);
        run_req("lhu10", 0, 0, 3'b101, 32'd10, 32'h0,         0, 32'h0000_BEEF, 0, 2, 1, 0);
        run_req("lw98",  0, 0, 3'b010, 32'd98, 32'h0,         0, 32'h0,         1, 1, 0, 0);
        run_req("sw96",  0, 1, 3'b010, 32'd96, 32'h0102_0304, 0, 32'h0,         0, 2, 0, 1);
        run_req("lw96",  0, 0, 3'b010, 32'd96, 32'h0,         0, 32'h0102_0304, 0, 2, 1, 0);
        run_req("lb99",  0, 0, 3'b000, 32'd99, 32'h0,         0, 32'h0000_0004, 0, 2, 1, 0);
        run_req("lh99",  0, 0, 3'b001, 32'd99, 32'h0,         0, 32'h0,         1, 1, 0, 0);
        run_req("ld110", 0, 0, 3'b110, 32'd0,  32'h0,         0, 32'h0,         1, 1, 0, 0);
        run_req("st011", 0, 1, 3'b011, 32'd0,  32'h1234_5678, 0, 32'h0,         1, 1, 0, 0);
        run_req("st100", 0, 1, 3'b100, 32'd0,  32'h1234_5678, 0, 32'h0,         1, 1, 0, 0);
        run_req("lwbig", 0, 0, 3'b010, 32'hFFFF_FFFE, 32'h0,  0, 32'h0,         1, 1, 0, 0);
`ifdef MISALIGN_TRAP_EN
        run_req("lh5",   0, 0, 3'b001, 32'd5,  32'h0,         0, 32'h0,         1, 1, 0, 0);
        run_req("lw9",   0, 0, 3'b010, 32'd9,  32'h0,         0, 32'h0,         1, 1, 0, 0);
        run_req("sh5",   0, 1, 3'b001, 32'd5,  32'h0000_ABCD, 0, 32'h0,         1, 1, 0, 0);
`else
        run_req("sh5",   0, 1, 3'b001, 32'd5,  32'h0000_ABCD, 0, 32'h0,         0, 2, 0, 1);
        run_req("lhu5",  0, 0, 3'b101, 32'd5,  32'h0,         0, 32'h0000_ABCD, 0, 2, 1, 0);
`endif

        // MEM_LAT=3 instance, load response back-pressured for 4 cycles
        run_req("l3.sw8", 1, 1, 3'b010, 32'd8, 32'hCAFE_F00D, 0, 32'h0,         0, 4, 0, 1);
        run_req("l3.lw8", 1, 0, 3'b010, 32'd8, 32'h0,         4, 32'hCAFE_F00D, 0, 4, 3, 0);

        // Reset landing on the write cycle of a store
        run_req("sw0",   0, 1, 3'b010, 32'd0,  32'h5566_7788, 0, 32'h0,         0, 2, 0, 1);
        @(negedge clk);
        req_is_store = 1'b1;
        req_funct3   = 3'b010;
        req_addr     = 32'd0;
        req_wdata    = 32'h1122_3344;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("rstacc.wr_en",     32'(mem_wr_en[0]), 32'd0);
        check("rstacc.req_ready", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("rstacc.resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rstacc.mem_addr",   mem_addr[0], 32'h0);
        check("rstacc.mem_wdata",  mem_wdata[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstacc.no_resp", 32'(resp_valid[0]), 32'd0);
        run_req("lw0",   0, 0, 3'b010, 32'd0,  32'h0,         0, 32'h5566_7788, 0, 2, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
